// File: rtl/mc_control_if.sv
// Control bundle between the multicycle main controller and the datapath.
// The controller (master) reads the IR and zero flag and drives every enable, select and status.
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src;
  logic [2:0]       alu_op;
  logic [1:0]       ext_op;
  logic [15:0]      imm16;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, zero,
    output pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, imm16, state, illegal, retired
  );

  modport slave (
    output instr, zero,
    input  pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, imm16, state, illegal, retired
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle main controller for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB sequencing,
// Moore-style datapath controls decoded from the held IR, and a retired-instruction counter.
module mc_control #(
  parameter bit ILLEGAL_TRAP = 1'b0,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         rst,
  mc_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_SLT    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_HIGH = 2'd1;
  localparam logic [1:0] EXT_SIGN = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_r, is_j, is_beq, is_addiu, is_ori, is_lui, is_lw, is_sw, legal;
  logic [2:0] r_alu_op;
  logic [1:0] ext_sel;

  logic       pc_write, ir_write, mem_write, reg_write, illegal, retire;
  logic [1:0] pc_src, ext_op;
  logic       reg_dst, mem_to_reg, alu_src;
  logic [2:0] alu_op;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];

  assign is_j     = (opcode == OP_J);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_addiu = (opcode == OP_ADDIU);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign legal    = is_r | is_j | is_beq | is_addiu | is_ori | is_lui | is_lw | is_sw;

  // An R-type only counts as recognised when its funct is one of the five supported ops.
  always_comb begin
    is_r     = 1'b0;
    r_alu_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        6'h21: begin is_r = 1'b1; r_alu_op = ALU_ADD; end
        6'h23: begin is_r = 1'b1; r_alu_op = ALU_SUB; end
        6'h24: begin is_r = 1'b1; r_alu_op = ALU_AND; end
        6'h25: begin is_r = 1'b1; r_alu_op = ALU_OR;  end
        6'h2A: begin is_r = 1'b1; r_alu_op = ALU_SLT; end
        default: ;
      endcase
    end
  end

  always_comb begin
    ext_sel = EXT_ZERO;
    if (is_lui) begin
      ext_sel = EXT_HIGH;
    end else if (is_addiu | is_lw | is_sw | is_beq) begin
      ext_sel = EXT_SIGN;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end else if (is_j) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ext_op = ext_sel;
        if (is_r) begin
          alu_op  = r_alu_op;
          state_d = S_WB;
        end else if (is_beq) begin
          alu_op   = ALU_SUB;
          pc_src   = PC_BRANCH;
          pc_write = bus.zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_src = 1'b1;
          alu_op  = is_ori ? ALU_OR : (is_lui ? ALU_PASS_B : ALU_ADD);
          state_d = (is_lw | is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        ext_op = ext_sel;
        if (is_sw) begin
          mem_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        ext_op     = ext_sel;
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset masks every enable in the same cycle so an abandoned instruction writes nothing.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.ext_op     = ext_op;
  assign bus.imm16      = bus.instr[15:0];
  assign bus.state      = state_q;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: two instances (no-trap/32-bit counter and trap/4-bit counter)
// run in lockstep against a per-instruction cycle-by-cycle reference model.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_v;
  logic        zero_v;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_ret0;
  logic [3:0]  exp_ret1;

  mc_control_if #(.CNT_W(32)) bus0 ();
  mc_control_if #(.CNT_W(4))  bus1 ();

  assign bus0.instr = instr_v;
  assign bus0.zero  = zero_v;
  assign bus1.instr = instr_v;
  assign bus1.zero  = zero_v;

  mc_control #(.ILLEGAL_TRAP(1'b0), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  mc_control #(.ILLEGAL_TRAP(1'b1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic [1:0]  pcs;
    logic        irw;
    logic        memw;
    logic        regw;
    logic        rdst;
    logic        m2r;
    logic        asrc;
    logic [2:0]  aop;
    logic [1:0]  ext;
    logic        ill;
    logic [15:0] imm;
  } outs_t;

  typedef enum int {
    I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_ORI, I_LUI, I_ADDIU, I_LW, I_SW, I_BEQ, I_J, I_BAD
  } kind_e;

  outs_t exp_q[$];

  function automatic outs_t sample0();
    outs_t o;
    o.st = bus0.state;   o.pcw = bus0.pc_write;   o.pcs = bus0.pc_src;
    o.irw = bus0.ir_write; o.memw = bus0.mem_write; o.regw = bus0.reg_write;
    o.rdst = bus0.reg_dst; o.m2r = bus0.mem_to_reg; o.asrc = bus0.alu_src;
    o.aop = bus0.alu_op; o.ext = bus0.ext_op; o.ill = bus0.illegal; o.imm = bus0.imm16;
    return o;
  endfunction

  function automatic outs_t sample1();
    outs_t o;
    o.st = bus1.state;   o.pcw = bus1.pc_write;   o.pcs = bus1.pc_src;
    o.irw = bus1.ir_write; o.memw = bus1.mem_write; o.regw = bus1.reg_write;
    o.rdst = bus1.reg_dst; o.m2r = bus1.mem_to_reg; o.asrc = bus1.alu_src;
    o.aop = bus1.alu_op; o.ext = bus1.ext_op; o.ill = bus1.illegal; o.imm = bus1.imm16;
    return o;
  endfunction

  function automatic kind_e classify(logic [31:0] w);
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h21: return I_ADDU;
          6'h23: return I_SUBU;
          6'h24: return I_AND;
          6'h25: return I_OR;
          6'h2A: return I_SLT;
          default: return I_BAD;
        endcase
      end
      6'h0D: return I_ORI;
      6'h0F: return I_LUI;
      6'h09: return I_ADDIU;
      6'h23: return I_LW;
      6'h2B: return I_SW;
      6'h04: return I_BEQ;
      6'h02: return I_J;
      default: return I_BAD;
    endcase
  endfunction

  function automatic outs_t blank(logic [2:0] st, logic [15:0] imm);
    outs_t c;
    c = '0;
    c.st = st;
    c.imm = imm;
    return c;
  endfunction

  // Reference model: the list of per-cycle outputs an instruction produces from FETCH to retirement.
  function automatic void build_expect(logic [31:0] w, logic z);
    kind_e k;
    outs_t c;
    logic [1:0] ext;
    logic [2:0] aop;
    logic is_r;
    k = classify(w);
    is_r = (k == I_ADDU || k == I_SUBU || k == I_AND || k == I_OR || k == I_SLT);
    exp_q.delete();

    c = blank(3'd0, w[15:0]); c.irw = 1'b1; c.pcw = 1'b1; exp_q.push_back(c);

    c = blank(3'd1, w[15:0]);
    if (k == I_J) begin
      c.pcw = 1'b1; c.pcs = 2'd2; exp_q.push_back(c); return;
    end
    if (k == I_BAD) begin
      c.ill = 1'b1; exp_q.push_back(c); return;
    end
    exp_q.push_back(c);

    case (k)
      I_ORI:                      ext = 2'd0;
      I_LUI:                      ext = 2'd1;
      I_ADDIU, I_LW, I_SW, I_BEQ: ext = 2'd2;
      default:                    ext = 2'd0;
    endcase
    case (k)
      I_SUBU, I_BEQ: aop = 3'd1;
      I_AND:         aop = 3'd2;
      I_OR, I_ORI:   aop = 3'd3;
      I_SLT:         aop = 3'd4;
      I_LUI:         aop = 3'd5;
      default:       aop = 3'd0;
    endcase

    c = blank(3'd2, w[15:0]); c.ext = ext; c.aop = aop;
    c.asrc = (k == I_ORI || k == I_LUI || k == I_ADDIU || k == I_LW || k == I_SW);
    if (k == I_BEQ) begin
      c.pcs = 2'd1; c.pcw = z; exp_q.push_back(c); return;
    end
    exp_q.push_back(c);

    if (k == I_LW || k == I_SW) begin
      c = blank(3'd3, w[15:0]); c.ext = ext;
      if (k == I_SW) begin
        c.memw = 1'b1; exp_q.push_back(c); return;
      end
      exp_q.push_back(c);
    end

    c = blank(3'd4, w[15:0]); c.ext = ext; c.regw = 1'b1; c.rdst = is_r; c.m2r = (k == I_LW);
    exp_q.push_back(c);
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    kind_e k;
    w = $urandom;
    k = kind_e'($urandom_range(0, 11));
    case (k)
      I_ADDU:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      I_SUBU:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      I_AND:   begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
      I_OR:    begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
      I_SLT:   begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
      I_ORI:   w[31:26] = 6'h0D;
      I_LUI:   w[31:26] = 6'h0F;
      I_ADDIU: w[31:26] = 6'h09;
      I_LW:    w[31:26] = 6'h23;
      I_SW:    w[31:26] = 6'h2B;
      I_BEQ:   w[31:26] = 6'h04;
      default: w[31:26] = 6'h02;
    endcase
    return w;
  endfunction

  // Runs one instruction from FETCH, checking every cycle and the retired counters afterwards.
  task automatic run_instr(input logic [31:0] w, input logic z, input bit chk1, input string name);
    outs_t o0, o1;
    instr_v = w;
    zero_v  = z;
    build_expect(w, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o0 = sample0();
      tests_run++;
      if (o0 !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL %s dut0 cycle %0d: got %h expected %h", name, i, o0, exp_q[i]);
      end
      if (chk1) begin
        o1 = sample1();
        tests_run++;
        if (o1 !== exp_q[i]) begin
          tests_failed++;
          $display("[TB] FAIL %s dut1 cycle %0d: got %h expected %h", name, i, o1, exp_q[i]);
        end
      end
      @(posedge clk); #1;
    end
    if (classify(w) != I_BAD) begin
      exp_ret0 = exp_ret0 + 32'd1;
      exp_ret1 = exp_ret1 + 4'd1;
    end
    tests_run++;
    if (bus0.retired !== exp_ret0) begin
      tests_failed++;
      $display("[TB] FAIL %s dut0 retired: got %0d expected %0d", name, bus0.retired, exp_ret0);
    end
    if (chk1) begin
      tests_run++;
      if (bus1.retired !== exp_ret1) begin
        tests_failed++;
        $display("[TB] FAIL %s dut1 retired: got %0d expected %0d", name, bus1.retired, exp_ret1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_v = 32'h00851021; zero_v = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.reg_write, bus0.illegal} !== 5'b0 ||
        {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write, bus1.illegal} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_enables: got %b/%b expected 00000",
               {bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.reg_write, bus0.illegal},
               {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write, bus1.illegal});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret0 = '0; exp_ret1 = '0;
    tests_run++;
    if (bus0.state !== 3'd0 || bus1.state !== 3'd0 || bus0.retired !== 32'd0 || bus1.retired !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got state %0d/%0d retired %0d/%0d expected 0/0 0/0",
               bus0.state, bus1.state, bus0.retired, bus1.retired);
    end
  endtask

  task automatic test_rtype();
    run_instr(32'h00851021, 1'b0, 1'b1, "addu");
    run_instr(32'h00851023, 1'b0, 1'b1, "subu");
    run_instr(32'h00851024, 1'b1, 1'b1, "and");
    run_instr(32'h00851025, 1'b0, 1'b1, "or");
    run_instr(32'h0085102A, 1'b1, 1'b1, "slt");
  endtask

  task automatic test_immediate();
    run_instr(32'h3C011234, 1'b0, 1'b1, "lui");
    run_instr(32'h34210F0F, 1'b0, 1'b1, "ori");
    run_instr(32'h2421FFFC, 1'b1, 1'b1, "addiu");
  endtask

  task automatic test_memory();
    run_instr(32'h8C220004, 1'b0, 1'b1, "lw");
    run_instr(32'hAC220004, 1'b0, 1'b1, "sw");
  endtask

  task automatic test_branch_jump();
    run_instr(32'h1022FFFE, 1'b1, 1'b1, "beq_taken");
    run_instr(32'h1022FFFE, 1'b0, 1'b1, "beq_not_taken");
    run_instr(32'h08000010, 1'b0, 1'b1, "j");
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      run_instr(rand_legal(), 1'($urandom_range(0, 1)), 1'b1, "random");
    end
  endtask

  task automatic test_illegal_trap();
    outs_t o1, e1;
    run_instr(32'hFC000000, 1'b0, 1'b1, "illegal_op3f");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      o1 = sample1();
      e1 = blank(3'd5, instr_v[15:0]);
      tests_run++;
      if (o1 !== e1) begin
        tests_failed++;
        $display("[TB] FAIL halt_hold cycle %0d: got %h expected %h", i, o1, e1);
      end
      @(posedge clk); #1;
    end
    run_instr(32'h00851020, 1'b0, 1'b0, "illegal_funct");
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.reg_write, bus0.illegal} !== 5'b0 ||
        {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write, bus1.illegal} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL trap_reset_enables: got %b/%b expected 00000",
               {bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.reg_write, bus0.illegal},
               {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write, bus1.illegal});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret0 = '0; exp_ret1 = '0;
    tests_run++;
    if (bus0.state !== 3'd0 || bus1.state !== 3'd0 || bus0.retired !== 32'd0 || bus1.retired !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL halt_exit: got state %0d/%0d retired %0d/%0d expected 0/0 0/0",
               bus0.state, bus1.state, bus0.retired, bus1.retired);
    end
  endtask

  task automatic test_reset_mid_instr();
    outs_t o0;
    logic [31:0] words [2];
    logic [2:0]  cut_state [2];
    words[0] = 32'h8C220004; cut_state[0] = 3'd3;
    words[1] = 32'h00851021; cut_state[1] = 3'd4;
    for (int t = 0; t < 2; t++) begin
      instr_v = words[t];
      zero_v  = 1'b0;
      build_expect(words[t], 1'b0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        o0 = sample0();
        tests_run++;
        if (o0 !== exp_q[i]) begin
          tests_failed++;
          $display("[TB] FAIL abort_prefix%0d cycle %0d: got %h expected %h", t, i, o0, exp_q[i]);
        end
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus0.state !== cut_state[t] || bus0.reg_write !== 1'b0 || bus0.mem_write !== 1'b0 ||
          bus0.pc_write !== 1'b0 || bus0.ir_write !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL abort_cycle%0d: got state %0d regw %b memw %b expected state %0d regw 0 memw 0",
                 t, bus0.state, bus0.reg_write, bus0.mem_write, cut_state[t]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret0 = '0; exp_ret1 = '0;
      tests_run++;
      if (bus0.state !== 3'd0 || bus0.retired !== 32'd0 || bus1.state !== 3'd0 || bus1.retired !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL abort_after%0d: got state %0d retired %0d expected state 0 retired 0",
                 t, bus0.state, bus0.retired);
      end
    end
  endtask

  task automatic test_counter_wrap();
    for (int n = 0; n < 16; n++) begin
      run_instr(rand_legal(), 1'($urandom_range(0, 1)), 1'b1, "wrap");
    end
  endtask

  initial begin
    exp_ret0 = '0;
    exp_ret1 = '0;
    test_reset();
    test_rtype();
    test_immediate();
    test_memory();
    test_branch_jump();
    test_random();
    test_illegal_trap();
    test_reset_mid_instr();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
